// File: rtl/func_pkg.sv
// rtl/func_pkg.sv - shared widths and state encoding for the minterm scanner
package func_pkg;

    localparam int NV_DEF = 4;
    localparam int TT_W   = 2 ** NV_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/lowbit_enc.sv
// rtl/lowbit_enc.sv - lowest-set-bit priority encoder with a single-bit-remaining flag
module lowbit_enc
    import func_pkg::*;
#(
    parameter int NV = NV_DEF
) (
    input  logic [2**NV-1:0] w,
    output logic [NV-1:0]    idx,
    output logic             any,
    output logic             single
);

    localparam int TT = 2 ** NV;
    localparam logic [TT-1:0] TT_ONE = TT'(1);

    // Scanning downward lets the lowest set bit overwrite any higher ones.
    always_comb begin
        idx = '0;
        for (int i = TT - 1; i >= 0; i--) begin
            if (w[i]) begin
                idx = i[NV-1:0];
            end
        end
    end

    assign any    = |w;
    assign single = any && ((w & (w - TT_ONE)) == '0);

endmodule

// File: rtl/func_minterm_scanner.sv
// rtl/func_minterm_scanner.sv - sweeps a Boolean function's inputs, captures its truth table
// and streams the minterm indices out over a valid/ready handshake.
module func_minterm_scanner
    import func_pkg::*;
#(
    parameter int NV     = NV_DEF,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NV-1:0]     abcd,
    input  logic              f,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [NV-1:0]     m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [2**NV-1:0]  tt,
    output logic [NV:0]       count
);

    localparam int TT = 2 ** NV;
    localparam logic [3:0]    SETTLE_L = 4'(SETTLE);
    localparam logic [NV-1:0] IDX_LAST = '1;
    localparam logic [NV-1:0] IDX_ONE  = NV'(1);
    localparam logic [NV:0]   CNT_ONE  = (NV + 1)'(1);
    localparam logic [TT-1:0] TT_ONE   = TT'(1);

    scan_state_t   state_q;
    logic [NV-1:0] idx_q;
    logic [3:0]    hold_q;
    logic [TT-1:0] tt_q;
    logic [NV:0]   count_q;
    logic [TT-1:0] w_q;

    logic [NV-1:0] enc_idx;
    logic          enc_any;
    logic          enc_single;

    lowbit_enc #(.NV(NV)) u_lowbit_enc (
        .w      (w_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            tt_q    <= '0;
            count_q <= '0;
            w_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        tt_q    <= '0;
                        count_q <= '0;
                        idx_q   <= '0;
                        hold_q  <= '0;
                    end
                end
                SCAN: begin
                    if (hold_q == SETTLE_L) begin
                        hold_q      <= '0;
                        tt_q[idx_q] <= f;
                        if (f) begin
                            count_q <= count_q + CNT_ONE;
                        end
                        // idx wraps to zero here, which also returns abcd to 0 on EMIT entry.
                        idx_q <= idx_q + IDX_ONE;
                        if (idx_q == IDX_LAST) begin
                            state_q <= EMIT;
                            w_q     <= tt_q | ((f ? TT_ONE : '0) << idx_q);
                        end
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                EMIT: begin
                    if (!enc_any) begin
                        state_q <= FIN;
                    end else if (m_ready) begin
                        w_q[enc_idx] <= 1'b0;
                        if (enc_single) begin
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Beat fields come straight from the working copy, so they hold while the consumer stalls.
    assign abcd    = idx_q;
    assign m_valid = (state_q == EMIT) && enc_any;
    assign m_idx   = enc_idx;
    assign m_last  = m_valid && enc_single;
    assign busy    = (state_q == SCAN) || (state_q == EMIT);
    assign done    = (state_q == FIN);
    assign tt      = tt_q;
    assign count   = count_q;

endmodule

// File: tb/tb_func_minterm_scanner.sv
// tb/tb_func_minterm_scanner.sv - directed and random checks of the minterm scanner
module tb_func_minterm_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [15:0] fn;
    logic        m_ready;

    logic [3:0]  abcd [3];
    logic [2:0]  f;
    logic [2:0]  m_valid;
    logic [2:0]  m_last;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [3:0]  m_idx [3];
    logic [15:0] tt [3];
    logic [4:0]  count [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign f[0] = fn[abcd[0]];
    assign f[1] = fn[abcd[1]];
    assign f[2] = fn[abcd[2]];

    func_minterm_scanner #(.NV(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abcd(abcd[0]), .f(f[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_idx(m_idx[0]), .m_last(m_last[0]),
        .busy(busy[0]), .done(done[0]), .tt(tt[0]), .count(count[0])
    );

    func_minterm_scanner #(.NV(4), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abcd(abcd[1]), .f(f[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_idx(m_idx[1]), .m_last(m_last[1]),
        .busy(busy[1]), .done(done[1]), .tt(tt[1]), .count(count[1])
    );

    func_minterm_scanner #(.NV(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abcd(abcd[2]), .f(f[2]),
        .m_valid(m_valid[2]), .m_ready(m_ready), .m_idx(m_idx[2]), .m_last(m_last[2]),
        .busy(busy[2]), .done(done[2]), .tt(tt[2]), .count(count[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset(input int u);
        check("rst_abcd",    32'(abcd[u]),    0);
        check("rst_m_valid", 32'(m_valid[u]), 0);
        check("rst_m_idx",   32'(m_idx[u]),   0);
        check("rst_m_last",  32'(m_last[u]),  0);
        check("rst_busy",    32'(busy[u]),    0);
        check("rst_done",    32'(done[u]),    0);
        check("rst_tt",      32'(tt[u]),      0);
        check("rst_count",   32'(count[u]),   0);
    endtask

    // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // abort_at >= 0 pulses reset once that many beats have been accepted.
    task automatic run(input int u, input logic [15:0] func, input int settle,
                       input int mode, input int abort_at);
        int q[$];
        int exp_cnt;
        int c;
        int popped;
        int pat[4] = '{1, 0, 0, 1};

        fn = func;
        for (int i = 0; i < 16; i++) begin
            if (func[i]) q.push_back(i);
        end
        exp_cnt = q.size();

        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        check("busy_scan", 32'(busy[u]), 1);

        for (int v = 0; v < 16; v++) begin
            for (int h = 0; h <= settle; h++) begin
                check($sformatf("abcd_v%0d_h%0d", v, h), 32'(abcd[u]), v);
                start[u] = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        start[u] = 1'b0;

        check("tt",         32'(tt[u]),    32'(func));
        check("count",      32'(count[u]), exp_cnt);
        check("abcd_emit",  32'(abcd[u]),  0);
        check("busy_emit",  32'(busy[u]),  1);

        if (exp_cnt == 0) begin
            check("empty_valid", 32'(m_valid[u]), 0);
            @(negedge clk);
        end else begin
            c      = 0;
            popped = 0;
            while (q.size() > 0 && c < 200) begin
                check("beat_valid", 32'(m_valid[u]), 1);
                check("beat_idx",   32'(m_idx[u]),   q[0]);
                check("beat_last",  32'(m_last[u]),  (q.size() == 1) ? 1 : 0);
                if (popped == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset(u);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                case (mode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = 1'(pat[c % 4]);
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                start[u] = 1'($urandom_range(0, 1));
                if (m_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
                @(negedge clk);
                c++;
            end
            check("emit_leftover", 32'(q.size()), 0);
        end

        check("fin_done",  32'(done[u]),    1);
        check("fin_busy",  32'(busy[u]),    0);
        check("fin_valid", 32'(m_valid[u]), 0);
        start[u] = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        check("idle_done",  32'(done[u]),  0);
        check("idle_busy",  32'(busy[u]),  0);
        check("hold_tt",    32'(tt[u]),    32'(func));
        check("hold_count", 32'(count[u]), exp_cnt);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = '0;
        fn      = '0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset(u);
        rst_n = 1'b1;

        run(0, 16'h87B6, 1, 0, -1);
        run(0, 16'h87B6, 1, 1, -1);
        run(0, 16'h0000, 1, 0, -1);
        run(0, 16'hFFFF, 1, 0, -1);
        run(0, 16'h87B6, 1, 0, 3);
        run(0, 16'h87B6, 1, 0, -1);
        run(1, 16'h87B6, 0, 1, -1);
        run(2, 16'h5A3C, 3, 2, -1);
        run(1, 16'hFFFF, 0, 2, -1);
        run(2, 16'h0001, 3, 0, -1);
        for (int k = 0; k < 4; k++) run(0, 16'($urandom), 1, 2, -1);
        run(1, 16'($urandom), 0, 2, -1);
        run(2, 16'($urandom), 3, 2, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/func_minterm_scanner.md
Name: func_minterm_scanner

Overview:
- Characterises a 4-input combinational Boolean function block. It walks the function's inputs through every combination, samples `f`, and captures the 16-bit truth table.
- It then streams the minterm list (indices where `f`=1) out over a valid/ready handshake.
- Sits beside the function-under-test in self-checking builds; this is the reverse of evaluation: from outputs back to the sum-of-minterms form.

Parameters:
- NV, 4, number of function inputs; table depth is 2**NV.
- SETTLE, 1, extra cycles each input vector is held before `f` is sampled (0..15).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE
- abcd  output  NV  drive to function inputs; MSB = A, LSB = D
- f  input  1  function output from the block under test
- m_valid  output  1  minterm beat valid
- m_ready  input  1  consumer accepts beat
- m_idx  output  NV  minterm index
- m_last  output  1  final minterm of this scan
- busy  output  1  high in SCAN or EMIT
- done  output  1  one-cycle pulse when the scan is complete
- tt  output  2**NV  captured truth table; bit i = f at abcd=i
- count  output  NV+1  number of minterms (0..2**NV)

Behaviour:
- Reset (async assert, sync deassert upstream): state IDLE; abcd=0, m_valid=0, m_idx=0, m_last=0, busy=0, done=0, tt=0, count=0.
- States: IDLE, SCAN, EMIT, FIN.
- IDLE: start=1 -> SCAN next cycle; clears tt, count and vector index idx, and sets abcd=0. start while busy is ignored, with no queuing.
- SCAN: each vector is held on abcd for SETTLE+1 cycles. On the last hold cycle:
  - tt[idx] <= f;
  - count increments if f=1;
  - idx increments.
- SCAN length: 16*(SETTLE+1) cycles for NV=4. After sampling idx=2**NV-1 -> EMIT; abcd returns to 0.
- EMIT, work copy: a working copy w of tt, including the bit sampled on the final SCAN cycle.
- EMIT, beat contents:
  - m_idx = lowest set bit of w;
  - m_valid=1 while w!=0;
  - m_last=1 when exactly one bit of w remains.
- EMIT, handshake: the beat completes on m_valid && m_ready; that bit of w is cleared. When the last beat is accepted -> FIN.
- EMIT, backpressure: while m_valid && !m_ready, m_idx and m_last hold stable. m_valid never drops without acceptance.
- EMIT, empty table: w=0 on entry -> FIN in one cycle with no beats; m_valid stays 0.
- First beat timing: m_valid is asserted the first cycle in EMIT. Maximum throughput is one beat per cycle.
- FIN: done=1 for exactly one cycle -> IDLE. tt and count hold until the next start.
- busy: 1 in SCAN and EMIT, 0 in IDLE and FIN.
- Reset mid-operation (any state): immediate return to reset values. A partially emitted list is abandoned and m_valid drops asynchronously.
- Simultaneous start and done: start arriving in the FIN cycle is ignored. start is accepted only in IDLE.
- Width rules: count is NV+1 bits so the all-ones table reports 16 without overflow. idx wraps are never observed because the state leaves SCAN at 2**NV-1.

Decomposition:
- Shared package func_pkg holds:
  - NV_DEF=4;
  - state enum scan_state_t {IDLE, SCAN, EMIT, FIN};
  - TT_W = 2**NV_DEF.
- One sub-module, `lowbit_enc` (input w[2**NV-1:0]; outputs idx[NV-1:0], any, single). It is a combinational lowest-set-bit priority encoder plus a popcount==1 flag, used by EMIT.

Test Plan:
- Function with minterms {1,2,4,5,7,8,9,10,15}, SETTLE=1, start, m_ready=1 -> SCAN 32 cycles; tt=16'h87B6, count=9; beats 1,2,4,5,7,8,9,10,15; m_last only on 15; done one cycle after the last beat.
- Same function, m_ready toggled 1-0-0-1 -> m_idx/m_last stable during stalls; sequence unchanged; no beat duplicated or lost.
- f tied 0 -> tt=0, count=0, zero beats, done exactly 1 cycle after EMIT entry; f tied 1 -> tt=16'hFFFF, count=16, beats 0..15, m_last on 15.
- rst_n pulsed low during EMIT after 3 beats -> all outputs at reset values immediately; next start gives a full, correct list.
- start asserted repeatedly while busy and in FIN -> ignored; abcd sequence 0..15, each held SETTLE+1 cycles (check SETTLE=0 and SETTLE=3).
